rr_priority_arbiter: RTL and testbench

//   Parametrised, registered successor to the combinational 8-to-3 priority encoder.

---
 rtl/rr_priority_arbiter.sv | 153 +++++++++++++++
 tb/tb_rr_priority_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// ---------------------------------------------------------------------------
// rr_priority_arbiter
//
// Registered N-way arbiter. It picks one requester from a request vector and
// presents that grant as a one-hot vector and as a binary index. Priority is
// either fixed or round-robin. Fixed priority means the highest set bit wins,
// which matches the old combinational 8-to-3 priority encoder. A valid/ready
// handshake holds each grant until the consumer takes it.
//
// Parameters
//   N      number of requesters (N >= 2)
//   IDX_W  width of the binary index, must equal $clog2(N)
//   RR_EN  1 = round-robin priority, 0 = fixed highest-bit-wins priority
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         request vector, bit i belongs to requester i
//   gnt_ready   consumer accepts the presented grant this cycle
//   gnt_valid   a grant is being presented
//   gnt_onehot  one-hot grant vector, zero when no grant is presented
//   gnt_idx     binary index of the granted requester, zero when idle
// ---------------------------------------------------------------------------
module rr_priority_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  // IDLE has no grant outstanding. GRANT holds a locked grant until transfer.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             gntValid_q;
  logic [N-1:0]     gntOnehot_q;
  logic [N-1:0]     gntOnehot_d;
  logic [IDX_W-1:0] gntIdx_q;

  logic             transfer;
  logic [IDX_W-1:0] searchStart;
  logic [IDX_W-1:0] searchIdx;
  logic             searchFound;
  logic [IDX_W-1:0] scanPos;

  assign transfer = gntValid_q & gnt_ready;

  // After index g is handed over, the round-robin pointer moves to the slot
  // just below g. That makes g the last candidate of the next scan.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (gntIdx_q == '0) ? LastIdx : (gntIdx_q - IDX_W'(1));
    end
  end

  // Pick where the downward scan begins. Fixed mode always starts at the top
  // bit. In round-robin mode, a search made in the same cycle as a transfer
  // must already use the advanced pointer. That keeps back-to-back grants fair.
  always_comb begin
    searchStart = LastIdx;
    if (RR_EN) begin
      searchStart = (state_q == GRANT) ? ptr_d : ptr_q;
    end
  end

  // Scan downward from searchStart and wrap from 0 to N-1. The first set
  // request bit found wins. The scan position steps down by one and wraps
  // explicitly, so N does not need to be a power of two.
  always_comb begin
    searchFound = 1'b0;
    searchIdx   = '0;
    scanPos     = searchStart;
    for (int j = 0; j < N; j++) begin
      if (!searchFound && req[scanPos]) begin
        searchFound = 1'b1;
        searchIdx   = scanPos;
      end
      scanPos = (scanPos == '0) ? LastIdx : (scanPos - IDX_W'(1));
    end
  end

  // Decode the winning index into the one-hot form that is loaded with it.
  always_comb begin
    gntOnehot_d = {{(N-1){1'b0}}, 1'b1} << searchIdx;
  end

  // Grant FSM with registered outputs. In GRANT the outputs stay frozen
  // while gnt_ready is low, whatever req does. On a transfer the pointer
  // advances and a new winner is loaded in the same cycle if one exists.
  // Otherwise the outputs clear and the FSM falls back to IDLE. gnt_ready in
  // IDLE has no effect because transfer needs gntValid_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= LastIdx;
      gntValid_q  <= 1'b0;
      gntOnehot_q <= '0;
      gntIdx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (searchFound) begin
            state_q     <= GRANT;
            gntValid_q  <= 1'b1;
            gntOnehot_q <= gntOnehot_d;
            gntIdx_q    <= searchIdx;
          end
        end
        GRANT: begin
          if (transfer) begin
            ptr_q <= ptr_d;
            if (searchFound) begin
              gntValid_q  <= 1'b1;
              gntOnehot_q <= gntOnehot_d;
              gntIdx_q    <= searchIdx;
            end else begin
              state_q     <= IDLE;
              gntValid_q  <= 1'b0;
              gntOnehot_q <= '0;
              gntIdx_q    <= '0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          gntValid_q  <= 1'b0;
          gntOnehot_q <= '0;
          gntIdx_q    <= '0;
        end
      endcase
    end
  end

  assign gnt_valid  = gntValid_q;
  assign gnt_onehot = gntOnehot_q;
  assign gnt_idx    = gntIdx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_priority_arbiter
//
// Directed bench for rr_priority_arbiter with N=8. It has one round-robin
// instance and one fixed-priority instance. Both share clock and reset. Each
// scenario task drives its own stimulus and compares against hand-computed
// expectations.
// ---------------------------------------------------------------------------
module tb_rr_priority_arbiter;

   localparam int N     = 8;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     reqRr;
   logic             readyRr;
   logic             validRr;
   logic [N-1:0]     onehotRr;
   logic [IDX_W-1:0] idxRr;
   logic [N-1:0]     reqFx;
   logic             readyFx;
   logic             validFx;
   logic [N-1:0]     onehotFx;
   logic [IDX_W-1:0] idxFx;

   int testCount = 0;
   int failCount = 0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   rr_priority_arbiter #(.N(N), .IDX_W(IDX_W), .RR_EN(1'b1)) dutRr (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (reqRr),
      .gnt_ready  (readyRr),
      .gnt_valid  (validRr),
      .gnt_onehot (onehotRr),
      .gnt_idx    (idxRr)
   );

   rr_priority_arbiter #(.N(N), .IDX_W(IDX_W), .RR_EN(1'b0)) dutFx (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (reqFx),
      .gnt_ready  (readyFx),
      .gnt_valid  (validFx),
      .gnt_onehot (onehotFx),
      .gnt_idx    (idxFx)
   );

   // Advance one rising edge, then settle 1 ns so outputs are sampled away
   // from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronously timed reset pulse that leaves both instances in IDLE.
   task automatic applyStimulus();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Reset with all requests asserted, then release and expect grant 7.
   task automatic test_reset();
      logic [11:0] got;
      readyRr = 1'b0;
      reqRr   = 8'hFF;
      rst_n   = 1'b0;
      tick();
      tick();
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== 12'h000) begin
         $display("[TB] FAIL reset_hold: got %03h expected 000", got);
         failCount++;
      end
      rst_n = 1'b1;
      tick();
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== {1'b1, 8'h80, 3'd7}) begin
         $display("[TB] FAIL reset_release: got %03h expected %03h", got, {1'b1, 8'h80, 3'd7});
         failCount++;
      end
   endtask

   // Fixed priority: the staircase pattern's highest bit k must win each time.
   task automatic test_fixed_staircase();
      logic [11:0] got;
      logic [11:0] exp;
      logic [7:0]  stair;
      readyFx = 1'b1;
      for (int k = 0; k < 8; k++) begin
         stair = 8'((1 << k) | ((1 << k) - 1));
         reqFx = stair;
         tick();
         exp = {1'b1, 8'(1 << k), 3'(k)};
         got = {validFx, onehotFx, idxFx};
         testCount++;
         if (got !== exp) begin
            $display("[TB] FAIL fixed_stair_k%0d: got %03h expected %03h", k, got, exp);
            failCount++;
         end
      end
      reqFx = 8'h00;
      tick();
      got = {validFx, onehotFx, idxFx};
      testCount++;
      if (got !== 12'h000) begin
         $display("[TB] FAIL fixed_drop: got %03h expected 000", got);
         failCount++;
      end
   endtask

   // Round-robin with all requests asserted: grants 7 down to 0, then wrap.
   task automatic test_rr_all_ones();
      int          seq [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
      logic [11:0] got;
      logic [11:0] exp;
      applyStimulus();
      reqRr   = 8'hFF;
      readyRr = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         exp = {1'b1, 8'(1 << seq[c]), 3'(seq[c])};
         got = {validRr, onehotRr, idxRr};
         testCount++;
         if (got !== exp) begin
            $display("[TB] FAIL rr_all_ones_c%0d: got %03h expected %03h", c, got, exp);
            failCount++;
         end
      end
      readyRr = 1'b0;
      reqRr   = 8'h00;
   endtask

   // Locked grant: req changes are ignored while gnt_ready is low.
   task automatic test_hold_lock();
      logic [11:0] got;
      applyStimulus();
      readyRr = 1'b0;
      reqRr   = 8'h20;
      tick();
      for (int c = 0; c < 4; c++) begin
         reqRr = (c % 2 == 0) ? 8'h01 : 8'h20;
         tick();
         got = {validRr, onehotRr, idxRr};
         testCount++;
         if (got !== {1'b1, 8'h20, 3'd5}) begin
            $display("[TB] FAIL hold_c%0d: got %03h expected %03h", c, got, {1'b1, 8'h20, 3'd5});
            failCount++;
         end
      end
      reqRr   = 8'h01;
      readyRr = 1'b1;
      tick();
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== {1'b1, 8'h01, 3'd0}) begin
         $display("[TB] FAIL hold_release: got %03h expected %03h", got, {1'b1, 8'h01, 3'd0});
         failCount++;
      end
      reqRr = 8'h00;
      tick();
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== 12'h000) begin
         $display("[TB] FAIL hold_idle: got %03h expected 000", got);
         failCount++;
      end
      readyRr = 1'b0;
   endtask

   // A single persistent requester is re-granted every cycle without bubbles.
   task automatic test_single_requester();
      logic [11:0] got;
      applyStimulus();
      reqRr   = 8'h08;
      readyRr = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         got = {validRr, onehotRr, idxRr};
         testCount++;
         if (got !== {1'b1, 8'h08, 3'd3}) begin
            $display("[TB] FAIL single_c%0d: got %03h expected %03h", c, got, {1'b1, 8'h08, 3'd3});
            failCount++;
         end
      end
      reqRr = 8'h00;
      tick();
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== 12'h000) begin
         $display("[TB] FAIL single_drop: got %03h expected 000", got);
         failCount++;
      end
      readyRr = 1'b0;
   endtask

   // An asynchronous reset pulse between edges clears the grant and pointer.
   task automatic test_async_reset();
      logic [11:0] got;
      applyStimulus();
      readyRr = 1'b0;
      reqRr   = 8'h20;
      tick();
      readyRr = 1'b1;
      tick();
      readyRr = 1'b0;
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== {1'b1, 8'h20, 3'd5}) begin
         $display("[TB] FAIL async_pre: got %03h expected %03h", got, {1'b1, 8'h20, 3'd5});
         failCount++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== 12'h000) begin
         $display("[TB] FAIL async_outputs: got %03h expected 000", got);
         failCount++;
      end
      testCount++;
      if (dutRr.ptr_q !== 3'd7) begin
         $display("[TB] FAIL async_ptr: got %0d expected 7", dutRr.ptr_q);
         failCount++;
      end
      rst_n = 1'b1;
      reqRr = 8'h81;
      tick();
      got = {validRr, onehotRr, idxRr};
      testCount++;
      if (got !== {1'b1, 8'h80, 3'd7}) begin
         $display("[TB] FAIL async_regrant: got %03h expected %03h", got, {1'b1, 8'h80, 3'd7});
         failCount++;
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      rst_n   = 1'b0;
      reqRr   = 8'h00;
      readyRr = 1'b0;
      reqFx   = 8'h00;
      readyFx = 1'b0;
      test_reset();
      test_fixed_staircase();
      test_rr_all_ones();
      test_hold_lock();
      test_single_requester();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
